// File: rtl/iiitb_elc_pkg.sv
// Shared definitions for the elevator scheduler.
// Contents:
//   state_t           - controller states IDLE, MOVE and DOOR_OPEN
//   DIR_UP / DIR_DOWN - encoding of the direction output
//   max_int           - elaboration-time helper that sizes the shared timer
package iiitb_elc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE      = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iiitb_elc_timer.sv
// Load/decrement/expire counter.
// The same counter times floor-to-floor travel and the door dwell.
// Ports:
//   i_clk      - clock; the count updates on the rising edge
//   i_rst      - asynchronous active-high reset; clears the count
//   i_load     - load i_load_val; takes priority over i_dec
//   i_load_val - value to load
//   i_dec      - decrement by one; the count holds once it reaches 0
//   o_expire   - high while the count is 1, so the next edge ends the period
module iiitb_elc_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    // A period loaded with N expires on the Nth edge after the load.
    assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/iiitb_elc_sched.sv
// Elevator controller using a SCAN schedule.
// Requests are latched into the pending vector. The car keeps moving in one
// direction while requests remain ahead of it, and reverses when none remain.
// Ports:
//   clk               - clock
//   reset             - asynchronous active-high reset
//   call_req          - one request bit per floor; a bit may be held
//   over_weight       - car overloaded; only sampled in DOOR_OPEN
//   door_hold         - obstruction or open button; only sampled in DOOR_OPEN
//   out_current_floor - one-hot current floor
//   direction         - 1 = up, 0 = down
//   moving            - the car is in MOVE
//   door_open         - the car is in DOOR_OPEN
//   complete          - IDLE with no outstanding requests
//   door_alert        - the door has been open for ALERT_TICKS cycles in a row
//   weight_alert      - over_weight was seen while the door was open
//   pending           - latched outstanding requests
module iiitb_elc_sched
    import iiitb_elc_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 8,
    parameter int ALERT_TICKS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  over_weight,
    input  logic                  door_hold,
    output logic [NUM_FLOORS-1:0] out_current_floor,
    output logic                  direction,
    output logic                  moving,
    output logic                  door_open,
    output logic                  complete,
    output logic                  door_alert,
    output logic                  weight_alert,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TMR_W  = $clog2(max_int(FLOOR_TICKS, DOOR_TICKS)) + 1;
    localparam int OPEN_W = $clog2(ALERT_TICKS + 1);
    localparam logic [TMR_W-1:0]  FLOOR_LOAD = TMR_W'(FLOOR_TICKS);
    localparam logic [TMR_W-1:0]  DOOR_LOAD  = TMR_W'(DOOR_TICKS);
    localparam logic [OPEN_W-1:0] OPEN_MAX   = OPEN_W'(ALERT_TICKS);

    state_t                r_state;
    logic [NUM_FLOORS-1:0] r_floor;
    logic                  r_dir;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [OPEN_W-1:0]     r_open_cnt;
    logic                  r_moving;
    logic                  r_door_open;
    logic                  r_complete;
    logic                  r_door_alert;
    logic                  r_weight_alert;

    state_t                w_state_nxt;
    logic [NUM_FLOORS-1:0] w_floor_nxt;
    logic                  w_dir_nxt;
    logic [NUM_FLOORS-1:0] w_pend_or;
    logic [NUM_FLOORS-1:0] w_pend_nxt;
    logic [NUM_FLOORS-1:0] w_below;
    logic [NUM_FLOORS-1:0] w_above;
    logic                  w_any_above;
    logic                  w_any_below;
    logic                  w_reopen;
    logic                  w_tmr_load;
    logic [TMR_W-1:0]      w_tmr_val;
    logic                  w_tmr_dec;
    logic                  w_tmr_expire;
    logic [OPEN_W-1:0]     w_open_nxt;

    iiitb_elc_timer #(
        .W(TMR_W)
    ) u_timer (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_expire   (w_tmr_expire)
    );

    // Masks are built directly from the one-hot floor.
    // Subtracting 1 from the one-hot value gives every floor below it.
    // (floor << 1) - 1 gives the current floor and every floor below it,
    // so its complement is every floor above.
    // At the top floor the shift overflows to 0, which leaves the above-mask empty.
    assign w_below     = r_floor - NUM_FLOORS'(1);
    assign w_above     = ~((r_floor << 1) - NUM_FLOORS'(1));
    assign w_any_above = |(r_pending & w_above);
    assign w_any_below = |(r_pending & w_below);

    // A new call for the current floor while the door is open counts like a
    // door_hold and restarts the dwell.
    assign w_reopen  = over_weight | door_hold | (|(call_req & r_floor));
    assign w_pend_or = r_pending | call_req;

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir;
        w_tmr_load  = 1'b0;
        w_tmr_val   = FLOOR_LOAD;
        w_tmr_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|(r_pending & r_floor)) begin
                    w_state_nxt = DOOR_OPEN;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = DOOR_LOAD;
                end else if (|r_pending) begin
                    w_state_nxt = MOVE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = FLOOR_LOAD;
                    if (r_dir == DIR_UP) begin
                        w_dir_nxt = w_any_above ? DIR_UP : DIR_DOWN;
                    end else begin
                        w_dir_nxt = w_any_below ? DIR_DOWN : DIR_UP;
                    end
                end
            end
            MOVE: begin
                if (w_tmr_expire) begin
                    if ((r_dir == DIR_UP) && !r_floor[NUM_FLOORS-1]) begin
                        w_floor_nxt = r_floor << 1;
                    end else if ((r_dir == DIR_DOWN) && !r_floor[0]) begin
                        w_floor_nxt = r_floor >> 1;
                    end
                    if (w_floor_nxt[NUM_FLOORS-1]) begin
                        w_dir_nxt = DIR_DOWN;
                    end else if (w_floor_nxt[0]) begin
                        w_dir_nxt = DIR_UP;
                    end
                    w_tmr_load = 1'b1;
                    // call_req is included so that a call for the landing floor,
                    // made on the same edge the car lands, still stops it there.
                    if (|(w_floor_nxt & w_pend_or)) begin
                        w_state_nxt = DOOR_OPEN;
                        w_tmr_val   = DOOR_LOAD;
                    end else begin
                        w_tmr_val   = FLOOR_LOAD;
                    end
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (w_reopen) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = DOOR_LOAD;
                end else begin
                    w_tmr_dec = 1'b1;
                    if (w_tmr_expire) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The floor being served is cleared on the edge that opens the door and
    // on every edge while the door stays open.
    assign w_pend_nxt = w_pend_or & ~((w_state_nxt == DOOR_OPEN) ? w_floor_nxt : '0);

    always_comb begin
        w_open_nxt = '0;
        if (w_state_nxt == DOOR_OPEN) begin
            if (r_state != DOOR_OPEN) begin
                w_open_nxt = OPEN_W'(1);
            end else if (r_open_cnt != OPEN_MAX) begin
                w_open_nxt = r_open_cnt + OPEN_W'(1);
            end else begin
                w_open_nxt = r_open_cnt;
            end
        end
    end

    // Every output is driven by a flop that loads the value for the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_floor        <= NUM_FLOORS'(1);
            r_dir          <= DIR_UP;
            r_pending      <= '0;
            r_open_cnt     <= '0;
            r_moving       <= 1'b0;
            r_door_open    <= 1'b0;
            r_complete     <= 1'b1;
            r_door_alert   <= 1'b0;
            r_weight_alert <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_floor        <= w_floor_nxt;
            r_dir          <= w_dir_nxt;
            r_pending      <= w_pend_nxt;
            r_open_cnt     <= w_open_nxt;
            r_moving       <= (w_state_nxt == MOVE);
            r_door_open    <= (w_state_nxt == DOOR_OPEN);
            r_complete     <= (w_state_nxt == IDLE) && (w_pend_nxt == '0);
            r_door_alert   <= (w_open_nxt == OPEN_MAX);
            r_weight_alert <= (r_state == DOOR_OPEN) && over_weight;
        end
    end

    assign out_current_floor = r_floor;
    assign direction         = r_dir;
    assign moving            = r_moving;
    assign door_open         = r_door_open;
    assign complete          = r_complete;
    assign door_alert        = r_door_alert;
    assign weight_alert      = r_weight_alert;
    assign pending           = r_pending;

endmodule

// File: doc/iiitb_elc_sched.md
IIITB_ELC_SCHED -- requirements
Module: iiitb_elc_sched

Interface
Parameters (name, default, meaning):
- REQ-001 The block SHALL have parameter NUM_FLOORS, default 8, giving the number of floors (2..32).
- REQ-002 The block SHALL have parameter FLOOR_TICKS, default 4, giving the clk cycles of travel per floor (>=1).
- REQ-003 The block SHALL have parameter DOOR_TICKS, default 8, giving the nominal door-open dwell in cycles (>=1).
- REQ-004 The block SHALL have parameter ALERT_TICKS, default 32, giving the continuous door-open cycles before door_alert (>DOOR_TICKS).

Ports (name, direction, width, meaning):
- REQ-005 clk, input, 1: the single clock; all state is updated on its rising edge.
- REQ-006 reset, input, 1: asynchronous, active-high reset.
- REQ-007 call_req, input, NUM_FLOORS: request vector, one bit per floor; a bit may be held for any number of cycles.
- REQ-008 over_weight, input, 1: load is above the limit; sampled only in DOOR_OPEN.
- REQ-009 door_hold, input, 1: obstruction or open-button; sampled only in DOOR_OPEN.
- REQ-010 out_current_floor, output, NUM_FLOORS: one-hot current floor.
- REQ-011 direction, output, 1: 1 means up, 0 means down.
- REQ-012 moving, output, 1: high in state MOVE.
- REQ-013 door_open, output, 1: high in state DOOR_OPEN.
- REQ-014 complete, output, 1: high when the state is IDLE and pending is 0.
- REQ-015 door_alert, output, 1: the door has been open continuously for at least ALERT_TICKS cycles.
- REQ-016 weight_alert, output, 1: over_weight is being observed in DOOR_OPEN.
- REQ-017 pending, output, NUM_FLOORS: the latched outstanding requests.

Function
- REQ-018 Each cycle, pending SHALL become pending OR call_req; the bit of the current floor SHALL be masked in DOOR_OPEN and on the edge that enters DOOR_OPEN.
- REQ-019 The FSM SHALL have the states IDLE, MOVE and DOOR_OPEN; all outputs SHALL be registered.
- REQ-020 IDLE with pending[cur] set: the FSM SHALL go to DOOR_OPEN next edge and clear that bit.
- REQ-021 IDLE with other pending bits: the FSM SHALL go to MOVE next edge, choosing direction by the SCAN rule.
- REQ-022 SCAN rule: keep the current direction if any pending floor lies that way; otherwise reverse.
- REQ-023 In MOVE, out_current_floor SHALL shift one position in the direction of travel every FLOOR_TICKS cycles.
- REQ-024 If a floor step lands on a pending floor, the FSM SHALL enter DOOR_OPEN on that same edge.
- REQ-025 out_current_floor SHALL never shift past floor 0 or floor NUM_FLOORS-1; at an end floor the direction SHALL reverse.
- REQ-026 over_weight and door_hold SHALL be ignored in MOVE.
- REQ-027 DOOR_OPEN SHALL load the dwell timer with DOOR_TICKS and go to IDLE when it expires.
- REQ-028 over_weight, door_hold, or a call_req bit for the current floor SHALL reload the dwell timer; weight_alert SHALL equal over_weight while in DOOR_OPEN and be 0 otherwise.
- REQ-029 An open-cycle counter SHALL count consecutive DOOR_OPEN cycles, saturating at ALERT_TICKS.
- REQ-030 door_alert SHALL be 1 when the open-cycle counter reaches ALERT_TICKS, and SHALL clear on leaving DOOR_OPEN.
- REQ-031 Latency: when a request for floor cur±k (k>=1) is captured in IDLE, door_open SHALL rise 1+k*FLOOR_TICKS edges after the capture edge.
- REQ-032 Requests arriving during MOVE SHALL be served when the car passes them in the current direction, and otherwise after reversal.

Reset
- REQ-033 While reset is high: state IDLE; out_current_floor = 1 (floor 0); direction = 1; pending = 0; all timers = 0; moving, door_open, door_alert, weight_alert = 0; complete = 1.
- REQ-034 Reset asserted mid-MOVE or mid-DOOR_OPEN SHALL abandon the operation and discard pending requests.
- REQ-035 The first edge after reset deasserts SHALL be able to capture call_req.

Structure
- REQ-036 Package iiitb_elc_pkg SHALL hold the state enum (IDLE, MOVE, DOOR_OPEN) and the DIR_UP/DIR_DOWN constants.
- REQ-037 The dwell/travel timer SHALL be sub-module iiitb_elc_timer, a load/decrement/expire counter of width $clog2(max(FLOOR_TICKS, DOOR_TICKS))+1.
- REQ-038 The SCAN above/below detection SHALL be combinational masks derived from out_current_floor, with no loops over time.

Verification (NUM_FLOORS=8, FLOOR_TICKS=4, DOOR_TICKS=8, ALERT_TICKS=32)
- REQ-039 Reset, then pulse call_req=8'h08 -> moving; floors 1,2,4,8 at 4-cycle spacing; door_open rises 13 edges after capture; pending=0; complete after 8 dwell cycles.
- REQ-040 Car at 8'h10 moving up; call_req=8'h44 in one cycle -> stop at 8'h40, then reverse and stop at 8'h04; direction flips once.
- REQ-041 In DOOR_OPEN, hold over_weight for 40 cycles -> weight_alert=1 throughout; door_alert=1 at open-cycle 32; door stays open; IDLE 8 cycles after release.
- REQ-042 Car at floor 8'h80; call_req=8'h80 -> DOOR_OPEN next edge, no movement, no shift beyond top floor.
- REQ-043 Assert reset mid-MOVE between floors 2 and 3 -> all outputs at their reset values immediately, pending=0.
- REQ-044 Assert door_hold in MOVE -> no effect; assert it in DOOR_OPEN for 5 cycles -> dwell extended to 8 cycles after release.
